hex_score_ctrl: RTL
===================

HEX_SCORE_CTRL -- requirements
Module: hex_score_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 12500000, meaning clk cycles per animation step (4 Hz at 50 MHz); legal range 2..2^24.
REQ-002 SHALL have port clk, input, 1, the single clock; all flops on rising edge.
REQ-003 SHALL have port rst, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port score, input, 14, unsigned binary score to display.
REQ-005 SHALL have port load, input, 1, request to capture score and start conversion.
REQ-006 SHALL have port mode, input, 2, display mode: 0 SCORE, 1 DASH, 2 SPIN, 3 BLANK.
REQ-007 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when the new BCD value is committed.
REQ-009 SHALL have port sel_bus, output, 30, six 5-bit decoder select codes; digit i (HEX i) is at [5i+4:5i].

Function
REQ-010 SHALL implement FSM IDLE -> CONV -> COMMIT -> IDLE.
REQ-011 In IDLE, load=1 SHALL capture min(score, 9999), clear the BCD shift register and enter CONV on the next edge.
REQ-012 CONV SHALL run exactly 14 double-dabble iterations, one per cycle: add 3 to each BCD nibble >=5, then shift left one bit.
REQ-013 COMMIT SHALL copy the 4-digit BCD result to the display register, pulse done for one cycle and return to IDLE.
REQ-014 Latency: load sampled at edge N gives busy=1 on cycles N+1..N+15, and done=1 plus the updated digits on cycle N+16.
REQ-015 load asserted while busy=1 SHALL be ignored, with no queuing; the display register SHALL hold its old value until COMMIT.
REQ-016 sel_bus SHALL be registered and updated every cycle from mode and the display register; a mode change SHALL take effect one cycle later.
REQ-017 SCORE mode: digit5=19 (S), digit4=17 (C), digits3..0 = BCD thousands..units.
REQ-018 DASH mode: all six digits SHALL be 16.
REQ-019 SPIN mode: all six digits SHALL be 22+phase; phase cycles 0..5 (segments A..F) and wraps 5->0.
REQ-020 The tick counter SHALL count 0..TICK_DIV-1 only in SPIN and advance phase when it wraps; entering SPIN from another mode SHALL zero both the counter and phase.
REQ-021 BLANK mode: all digits SHALL be 31, which the decoder renders as all segments off.
REQ-022 Conversion SHALL proceed independently of mode; a COMMIT during a non-SCORE mode SHALL still update the display register.
REQ-023 score values 10000..16383 SHALL display as 9999.

Reset
REQ-024 With rst=0 asynchronously: FSM=IDLE, busy=0, done=0, display BCD=0000, tick counter=0, phase=0, and sel_bus = all digits 31.
REQ-025 Reset asserted mid-CONV SHALL abort the conversion; no done pulse, and the display stays 0000 after release.
REQ-026 The first edge after release SHALL drive sel_bus per mode from the reset state.

Configuration
REQ-027 Macro HEX_BLANK_LZ_EN: when defined, leading-zero digits among digits3..1 SHALL output 31; the units digit is never blanked.
REQ-028 Without HEX_BLANK_LZ_EN: all four score digits SHALL show numerals, including leading zeros (code 0).

Verification
REQ-029 Bench: reset release, mode=0, no load -> sel_bus digits5..0 = 19,17,31,31,31,0 (macro defined) or 19,17,0,0,0,0 (undefined).
REQ-030 Bench: mode=0, score=1234, load pulse at edge N -> busy on N+1..N+15; done and digits3..0 = 1,2,3,4 on N+16.
REQ-031 Bench: score=16000 load -> digits3..0 = 9,9,9,9; then score=7, load asserted at N+5 during busy -> ignored, result still 9999.
REQ-032 Bench: TICK_DIV=4, mode 0->2 -> digits = 22 for 4 cycles, then 23..27, then wrap back to 22; mode 1 -> all 16 one cycle later.
REQ-033 Bench: score=50 load, rst=0 at N+7 -> busy=0 and sel_bus all 31 immediately; after release, no done pulse and digits show 0 (units).
REQ-034 Bench: mode=3 during conversion of 805 -> all 31; done still pulses; switching to mode=0 shows 31,8,0,5 (macro defined).

Source files
------------

// File: rtl/hex_score_ctrl.sv
// Score-to-seven-segment select controller: double-dabble BCD conversion plus SCORE/DASH/SPIN/BLANK display modes.
// Optional feature macro HEX_BLANK_LZ_EN blanks leading zeros among digits 3..1.
module hex_score_ctrl #(
    parameter int TICK_DIV = 12500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] score,
    input  logic        load,
    input  logic [1:0]  mode,
    output logic        busy,
    output logic        done,
    output logic [29:0] sel_bus
);

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] MODE_SCORE = 2'd0;
    localparam logic [1:0] MODE_DASH  = 2'd1;
    localparam logic [1:0] MODE_SPIN  = 2'd2;

    localparam logic [4:0] CODE_S     = 5'd19;
    localparam logic [4:0] CODE_C     = 5'd17;
    localparam logic [4:0] CODE_DASH  = 5'd16;
    localparam logic [4:0] CODE_SEG_A = 5'd22;
    localparam logic [4:0] CODE_OFF   = 5'd31;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [29:0]    sr_reg, sr_next;
    logic [3:0]     iter_reg, iter_next;
    logic [15:0]    disp_reg, disp_next;
    logic           done_reg, done_next;
    logic [TW-1:0]  tick_reg, tick_next;
    logic [2:0]     phase_reg, phase_next;
    logic           spin_reg;
    logic [29:0]    sel_reg, sel_next;

    logic [13:0]    score_sat;
    logic [15:0]    bcd_adj;

    assign score_sat = (score > 14'd9999) ? 14'd9999 : score;

    // Double-dabble correction: BCD digits live in sr_reg[29:14], binary in [13:0].
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_adj
            assign bcd_adj[4*gi+3:4*gi] = (sr_reg[14+4*gi+3:14+4*gi] >= 4'd5)
                                        ? sr_reg[14+4*gi+3:14+4*gi] + 4'd3
                                        : sr_reg[14+4*gi+3:14+4*gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        sr_next    = sr_reg;
        iter_next  = iter_reg;
        disp_next  = disp_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (load) begin
                    sr_next    = {16'd0, score_sat};
                    iter_next  = 4'd0;
                    state_next = CONV;
                end
            end
            CONV: begin
                sr_next   = {bcd_adj[14:0], sr_reg[13:0], 1'b0};
                iter_next = iter_reg + 4'd1;
                if (iter_reg == 4'd13) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                disp_next  = sr_reg[29:14];
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Spin animation; counter and phase restart whenever SPIN is freshly entered.
    always_comb begin
        tick_next  = '0;
        phase_next = 3'd0;
        if (mode == MODE_SPIN && spin_reg) begin
            if (tick_reg == TW'(TICK_DIV - 1)) begin
                tick_next  = '0;
                phase_next = (phase_reg == 3'd5) ? 3'd0 : phase_reg + 3'd1;
            end else begin
                tick_next  = tick_reg + 1'b1;
                phase_next = phase_reg;
            end
        end
    end

    // Display selects use disp_next so committed digits appear together with done.
    always_comb begin
        logic [4:0] d3, d2, d1, d0;
        d3 = {1'b0, disp_next[15:12]};
        d2 = {1'b0, disp_next[11:8]};
        d1 = {1'b0, disp_next[7:4]};
        d0 = {1'b0, disp_next[3:0]};
`ifdef HEX_BLANK_LZ_EN
        if (disp_next[15:12] == 4'd0) d3 = CODE_OFF;
        if (disp_next[15:8]  == 8'd0) d2 = CODE_OFF;
        if (disp_next[15:4]  == 12'd0) d1 = CODE_OFF;
`endif
        sel_next = {6{CODE_OFF}};
        case (mode)
            MODE_SCORE: sel_next = {CODE_S, CODE_C, d3, d2, d1, d0};
            MODE_DASH:  sel_next = {6{CODE_DASH}};
            MODE_SPIN:  sel_next = {6{CODE_SEG_A + {2'b00, phase_next}}};
            default:    sel_next = {6{CODE_OFF}};
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            sr_reg    <= '0;
            iter_reg  <= '0;
            disp_reg  <= '0;
            done_reg  <= 1'b0;
            tick_reg  <= '0;
            phase_reg <= 3'd0;
            spin_reg  <= 1'b0;
            sel_reg   <= {6{CODE_OFF}};
        end else begin
            state_reg <= state_next;
            sr_reg    <= sr_next;
            iter_reg  <= iter_next;
            disp_reg  <= disp_next;
            done_reg  <= done_next;
            tick_reg  <= tick_next;
            phase_reg <= phase_next;
            spin_reg  <= (mode == MODE_SPIN);
            sel_reg   <= sel_next;
        end
    end

    assign busy    = (state_reg != IDLE);
    assign done    = done_reg;
    assign sel_bus = sel_reg;

endmodule
